// File: rtl/uart_rx.sv
// Oversampling asynchronous serial receiver, LSB-first, one stop bit.
// Companion of uart_tx; shares its baud-select encoding.
module uart_rx #(
    parameter int         data_bits                 = 8,
    parameter int         received_bit_counter_bits = 4,
    parameter logic [2:0] br                        = 3'b000
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [data_bits-1:0] DBUS,
    output logic                 rxd_doneH,
    output logic                 rxd_ferrH,
    output logic                 rxd_busyH
);

    localparam int CPB = 16 << br;
    localparam int CW  = 12;
    localparam int BW  = received_bit_counter_bits;

    localparam logic [CW-1:0] half_m1  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] full_m1  = CW'(CPB - 1);
    localparam logic [BW-1:0] last_bit = BW'(data_bits - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic [data_bits-1:0] sh, sh_n;
    logic [data_bits-1:0] dbus_n;
    logic                 done_n, ferr_n;
    logic                 rxd_m, rxd_s;

    // Idle-high reset value keeps a fresh reset from looking like a start bit
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            sh        <= '0;
            DBUS      <= '0;
            rxd_doneH <= 1'b0;
            rxd_ferrH <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bitcnt    <= bitcnt_n;
            sh        <= sh_n;
            DBUS      <= dbus_n;
            rxd_doneH <= done_n;
            rxd_ferrH <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        bitcnt_n = bitcnt;
        sh_n     = sh;
        dbus_n   = DBUS;
        done_n   = 1'b0;
        ferr_n   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (cnt == half_m1) begin
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    state_n  = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == full_m1) begin
                    cnt_n = '0;
                    sh_n  = {rxd_s, sh[data_bits-1:1]};
                    if (bitcnt == last_bit) begin
                        bitcnt_n = '0;
                        state_n  = STOP;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt == full_m1) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        dbus_n  = sh;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAITHI;
                    end
                end
            end
            WAITHI: begin
                // A held-low line must go high before another start is armed
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign rxd_busyH = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, glitches, errors, reset and
// loopback from a behavioural transmitter at two baud selections.
module tb_uart_rx;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       rxd0, rxd3;
    logic [7:0] DBUS0, DBUS3;
    logic       done0, ferr0, busy0;
    logic       done3, ferr3, busy3;

    int checks   = 0;
    int failures = 0;

    int   cycle = 0;
    int   lane  = 0;
    int   fall_cycle = 0;
    int   done_cnt0 = 0, ferr_cnt0 = 0, done_cycle0 = 0;
    int   run0 = 0, max_run0 = 0;
    int   done_cnt3 = 0;
    int   tx_frames3 = 0;
    logic busy_seen0 = 1'b0;
    logic both0 = 1'b0;
    logic [7:0] words0[$];

    uart_rx #(
        .data_bits(8),
        .received_bit_counter_bits(4),
        .br(3'b000)
    ) u0 (
        .sysclk(sysclk),
        .rst_n(rst_n),
        .rxd(rxd0),
        .DBUS(DBUS0),
        .rxd_doneH(done0),
        .rxd_ferrH(ferr0),
        .rxd_busyH(busy0)
    );

    uart_rx #(
        .data_bits(8),
        .received_bit_counter_bits(4),
        .br(3'b011)
    ) u3 (
        .sysclk(sysclk),
        .rst_n(rst_n),
        .rxd(rxd3),
        .DBUS(DBUS3),
        .rxd_doneH(done3),
        .rxd_ferrH(ferr3),
        .rxd_busyH(busy3)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cycle <= cycle + 1;

    always @(negedge sysclk) begin
        if (done0) begin
            done_cnt0++;
            done_cycle0 = cycle;
            words0.push_back(DBUS0);
            run0++;
            if (run0 > max_run0) max_run0 = run0;
        end else begin
            run0 = 0;
        end
        if (ferr0) ferr_cnt0++;
        if (busy0) busy_seen0 = 1'b1;
        if (done0 && ferr0) both0 = 1'b1;
        if (done3) done_cnt3++;
    end

    task automatic line(input logic v, input int n);
        if (lane == 0) rxd0 = v;
        else rxd3 = v;
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int cpb);
        fall_cycle = cycle;
        line(1'b0, cpb);
        for (int i = 0; i < 8; i++) line(d[i], cpb);
        line(stop, cpb);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxd0  = 1'b1;
        rxd3  = 1'b1;
        repeat (3) @(negedge sysclk);
        checks++;
        if (DBUS0 !== 8'h00) begin
            failures++;
            $display("FAIL reset_dbus got=%h want=00", DBUS0);
        end
        checks++;
        if (done0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want=0", done0);
        end
        checks++;
        if (ferr0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b want=0", ferr0);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy0);
        end
        rst_n = 1'b1;
        line(1'b1, 10);
    endtask

    task automatic test_basic;
        int d0, f0;
        lane = 0;
        d0 = done_cnt0;
        f0 = ferr_cnt0;
        max_run0 = 0;
        send_frame(8'hA5, 1'b1, 16);
        line(1'b1, 20);
        checks++;
        if (DBUS0 !== 8'hA5) begin
            failures++;
            $display("FAIL basic_dbus got=%h want=a5", DBUS0);
        end
        checks++;
        if (done_cnt0 - d0 !== 1) begin
            failures++;
            $display("FAIL basic_done_cnt got=%0d want=1", done_cnt0 - d0);
        end
        checks++;
        if (max_run0 !== 1) begin
            failures++;
            $display("FAIL basic_pulse_width got=%0d want=1", max_run0);
        end
        checks++;
        if (done_cycle0 - fall_cycle !== 155) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=155",
                     done_cycle0 - fall_cycle);
        end
        checks++;
        if (ferr_cnt0 - f0 !== 0) begin
            failures++;
            $display("FAIL basic_ferr got=%0d want=0", ferr_cnt0 - f0);
        end
    endtask

    task automatic test_back_to_back;
        int f0;
        lane = 0;
        words0.delete();
        f0 = ferr_cnt0;
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        line(1'b1, 20);
        checks++;
        if (words0.size() !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=2", words0.size());
        end else begin
            checks++;
            if (words0[0] !== 8'h00) begin
                failures++;
                $display("FAIL b2b_first got=%h want=00", words0[0]);
            end
            checks++;
            if (words0[1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_second got=%h want=ff", words0[1]);
            end
        end
        checks++;
        if (ferr_cnt0 - f0 !== 0) begin
            failures++;
            $display("FAIL b2b_ferr got=%0d want=0", ferr_cnt0 - f0);
        end
    endtask

    task automatic test_false_start;
        int d0;
        lane = 0;
        d0 = done_cnt0;
        busy_seen0 = 1'b0;
        line(1'b0, 4);
        line(1'b1, 40);
        checks++;
        if (busy_seen0 !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_seen got=%b want=1", busy_seen0);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_end got=%b want=0", busy0);
        end
        checks++;
        if (done_cnt0 - d0 !== 0) begin
            failures++;
            $display("FAIL glitch_strobe got=%0d want=0", done_cnt0 - d0);
        end
        send_frame(8'h3C, 1'b1, 16);
        line(1'b1, 20);
        checks++;
        if (DBUS0 !== 8'h3C) begin
            failures++;
            $display("FAIL glitch_next_dbus got=%h want=3c", DBUS0);
        end
    endtask

    task automatic test_framing;
        int d0, f0;
        lane = 0;
        d0 = done_cnt0;
        f0 = ferr_cnt0;
        send_frame(8'h5A, 1'b0, 16);
        line(1'b0, 40);
        checks++;
        if (ferr_cnt0 - f0 !== 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d want=1", ferr_cnt0 - f0);
        end
        checks++;
        if (done_cnt0 - d0 !== 0) begin
            failures++;
            $display("FAIL ferr_done got=%0d want=0", done_cnt0 - d0);
        end
        checks++;
        if (DBUS0 !== 8'h3C) begin
            failures++;
            $display("FAIL ferr_dbus_hold got=%h want=3c", DBUS0);
        end
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL ferr_waithi_busy got=%b want=1", busy0);
        end
        line(1'b1, 20);
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL ferr_release_busy got=%b want=0", busy0);
        end
        send_frame(8'h81, 1'b1, 16);
        line(1'b1, 20);
        checks++;
        if (DBUS0 !== 8'h81) begin
            failures++;
            $display("FAIL ferr_next_dbus got=%h want=81", DBUS0);
        end
        checks++;
        if (ferr_cnt0 - f0 !== 1) begin
            failures++;
            $display("FAIL ferr_total got=%0d want=1", ferr_cnt0 - f0);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int         d0;
        lane = 0;
        d = 8'hC3;
        d0 = done_cnt0;
        line(1'b0, 16);
        for (int i = 0; i < 3; i++) line(d[i], 16);
        line(d[3], 8);
        rst_n = 1'b0;
        #1;
        checks++;
        if (DBUS0 !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_dbus got=%h want=00", DBUS0);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_busy got=%b want=0", busy0);
        end
        checks++;
        if (done0 !== 1'b0 || ferr0 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_strobes got=%b%b want=00", done0, ferr0);
        end
        @(negedge sysclk);
        rst_n = 1'b1;
        line(1'b1, 40);
        checks++;
        if (done_cnt0 - d0 !== 0) begin
            failures++;
            $display("FAIL rstmid_abort got=%0d want=0", done_cnt0 - d0);
        end
        send_frame(8'hC3, 1'b1, 16);
        line(1'b1, 20);
        checks++;
        if (DBUS0 !== 8'hC3) begin
            failures++;
            $display("FAIL rstmid_next_dbus got=%h want=c3", DBUS0);
        end
        checks++;
        if (done_cnt0 - d0 !== 1) begin
            failures++;
            $display("FAIL rstmid_next_cnt got=%0d want=1", done_cnt0 - d0);
        end
    endtask

    task automatic test_loopback;
        int d0;
        lane = 0;
        d0 = done_cnt0;
        send_frame(8'hA5, 1'b1, 16);
        line(1'b1, 20);
        checks++;
        if (DBUS0 !== 8'hA5 || done_cnt0 - d0 !== 1) begin
            failures++;
            $display("FAIL loop0 got=%h/%0d want=a5/1", DBUS0, done_cnt0 - d0);
        end
        lane = 1;
        tx_frames3 = 0;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'hA5, 1'b1, 128);
            tx_frames3++;
        end
        line(1'b1, 200);
        checks++;
        if (DBUS3 !== 8'hA5) begin
            failures++;
            $display("FAIL loop3_dbus got=%h want=a5", DBUS3);
        end
        checks++;
        if (done_cnt3 !== tx_frames3) begin
            failures++;
            $display("FAIL loop3_count got=%0d want=%0d", done_cnt3, tx_frames3);
        end
        checks++;
        if (ferr3 !== 1'b0 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL loop3_idle got=%b%b want=00", ferr3, busy3);
        end
        lane = 0;
    endtask

    initial begin
        rxd0  = 1'b1;
        rxd3  = 1'b1;
        rst_n = 1'b0;
        @(negedge sysclk);
        test_reset;
        test_basic;
        test_back_to_back;
        test_false_start;
        test_framing;
        test_reset_mid;
        test_loopback;
        checks++;
        if (both0 !== 1'b0 || max_run0 > 1) begin
            failures++;
            $display("FAIL strobe_excl got=%b/%0d want=0/<=1", both0, max_run0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of `uart_tx`. It oversamples the `rxd` line with `sysclk`, detects start bits and samples each bit at mid-bit. It assembles an LSB-first frame of `data_bits` data bits plus one stop bit, then presents the word on `DBUS` with a one-cycle `rxd_doneH` strobe. It uses the same `br` baud-select encoding as `uart_tx`, so a matching pair loops back directly.

## Interface
- `data_bits`, 8, data bits per frame (5..9)
- `received_bit_counter_bits`, 4, width of the data-bit counter; must satisfy 2^width > `data_bits`
- `br`, 3'b000, baud select; clocks per bit CPB = 16 << `br` (000→16 … 111→2048)

- `sysclk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rxd` input 1: serial line, idle high, asynchronous to `sysclk`.
- `DBUS` output `data_bits`: last correctly framed word, held until the next good frame.
- `rxd_doneH` output 1: one-cycle pulse, `DBUS` newly valid.
- `rxd_ferrH` output 1: one-cycle pulse, stop bit sampled low (framing error).
- `rxd_busyH` output 1: high from start detection until return to IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) to give `rxd_s`. Only `rxd_s` is used internally.
- Reset values: `DBUS`=0, `rxd_doneH`=0, `rxd_ferrH`=0, `rxd_busyH`=0. State resets to IDLE; bit counter, clock counter and shift register reset to 0.
- States: IDLE, START, DATA, STOP, WAITHI.
  - IDLE: `rxd_s`=0 → START, clock counter cleared.
  - START: at counter = CPB/2−1, sample `rxd_s`. If 0 → DATA, counter cleared. If 1 (glitch) → IDLE, no strobe.
  - DATA: every CPB clocks, sample `rxd_s` and shift right into the MSB of the shift register (LSB-first arrival). After `data_bits` samples → STOP.
  - STOP: after CPB clocks, sample `rxd_s`.
    - If 1: load `DBUS`, pulse `rxd_doneH`, go to IDLE.
    - If 0: pulse `rxd_ferrH`, leave `DBUS` unchanged, go to WAITHI.
  - WAITHI: stay until `rxd_s`=1, then IDLE. A held-low line or break never produces a second frame.
- `rxd_doneH` and `rxd_ferrH` are never high together and never high for more than one cycle.
- There is no handshake or overrun flag. A new good frame overwrites `DBUS` and the consumer must capture it on `rxd_doneH`.
- A start bit is accepted in the cycle immediately after the return to IDLE, so back-to-back frames with exactly one stop bit are received.
- Reset asserted mid-frame clears everything immediately. No strobe is produced for the aborted frame.

## Timing
- Define cycle 0 as the first cycle with `rxd_s`=0 in IDLE. This is 2 cycles after `rxd` falls.
- Start sample at cycle CPB/2.
- Data bit i (i=0..`data_bits`−1) sampled at cycle CPB/2 + (i+1)·CPB.
- Stop sample at cycle CPB/2 + (`data_bits`+1)·CPB.
- `rxd_doneH`/`rxd_ferrH` are high, and `DBUS` is updated, in the next cycle (registered outputs).
- Latency from the `rxd` falling edge to `rxd_doneH`, for `br`=000 and `data_bits`=8: 2 + 8 + 9·16 + 1 = 155 cycles.
- `rxd_busyH` rises the cycle after cycle 0. It falls the cycle IDLE is re-entered, coincident with the strobe.
- Tolerated baud mismatch is about ±4% of CPB at 10 bits/frame.

## Test plan
- **Basic frame:** `br`=000, drive 8'hA5 as start, bits 1,0,1,0,0,1,0,1 (LSB first), then stop, 16 clocks per bit → `DBUS`=8'hA5. `rxd_doneH` is high for exactly one cycle, 155 cycles after the falling edge. `rxd_ferrH` stays 0.
- **Back-to-back frames:** 8'h00 then 8'hFF with one stop bit between them → two `rxd_doneH` pulses, `DBUS`=8'h00 then 8'hFF, no `rxd_ferrH`.
- **False start:** `rxd` low for 4 clocks, then high → `rxd_busyH` pulses, returns to IDLE, no strobe. A following frame 8'h3C is received correctly.
- **Framing error:** frame 8'h5A with the stop bit low, line then held low for 40 clocks → one `rxd_ferrH` pulse and `DBUS` keeps its previous value. No further activity until `rxd` goes high, after which 8'h81 is received normally.
- **Reset mid-frame:** pull `rst_n` low during data bit 3 → all outputs read 0 immediately. After release, frame 8'hC3 gives `DBUS`=8'hC3.
- **Loopback:** connect `uart_tx` (`br`=000, `DBUS`=8'hA5, `txd_startH`=1) to `rxd`, and repeat at `br`=011 → `DBUS`=8'hA5 with one `rxd_doneH` per `txd_doneH`.
